// File: rtl/dis_pal_pkg.sv
// Shared constants for the PAL test-pattern source: packet types, FSM states
// and the pattern selector codes.
package dis_pal_pkg;

  localparam logic [3:0] PKT_CTRL  = 4'hF;
  localparam logic [3:0] PKT_VIDEO = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CTRL_HDR = 3'd1,
    ST_CTRL_DAT = 3'd2,
    ST_VID_HDR  = 3'd3,
    ST_VID_PIX  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_FLAT  = 2'd3
  } pattern_e;

endpackage

// File: rtl/dis_pal_pattern_pixel.sv
// Combinational pixel value for one coordinate of the selected test pattern.
// Counters and sequencing live in the top; this block only maps position to value.
module dis_pal_pattern_pixel
  import dis_pal_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int CHECK_LOG2 = 5
) (
  input  pattern_e              pattern_i,
  input  logic [15:0]           cnt_x_i,
  input  logic [15:0]           cnt_y_i,
  input  logic [2:0]            bar_idx_i,
  input  logic [DATA_WIDTH-1:0] flat_value_i,
  output logic [DATA_WIDTH-1:0] pixel_o
);

  logic checkBit;

  // Square parity: bit 0 of the xor of both cell indices.
  assign checkBit = |(((cnt_x_i ^ cnt_y_i) >> CHECK_LOG2) & 16'd1);

  always_comb begin
    pixel_o = '0;
    case (pattern_i)
      PAT_BARS:  pixel_o = DATA_WIDTH'(3'd7 - bar_idx_i) << (DATA_WIDTH - 3);
      PAT_RAMP:  pixel_o = DATA_WIDTH'(cnt_x_i);
      PAT_CHECK: pixel_o = checkBit ? {DATA_WIDTH{1'b1}} : '0;
      PAT_FLAT:  pixel_o = flat_value_i;
      default:   pixel_o = '0;
    endcase
  end

endmodule

// File: rtl/dis_pal_pattern_gen.sv
// Avalon-ST Video test-pattern source: endless control + video packet pairs
// for the PAL display path, with a completed-frame counter.
module dis_pal_pattern_gen
  import dis_pal_pkg::*;
#(
  parameter int         DATA_WIDTH       = 10,
  parameter int         IM_WIDTH         = 720,
  parameter int         IM_HEIGHT        = 576,
  parameter logic [3:0] INTERLACE_NIBBLE = 4'h0,
  parameter int         CHECK_LOG2       = 5
) (
  input  logic                  vst_clk,
  input  logic                  vst_rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] flat_value,
  output logic [DATA_WIDTH-1:0] vst_data,
  output logic                  vst_valid,
  input  logic                  vst_ready,
  output logic                  vst_startofpacket,
  output logic                  vst_endofpacket,
  output logic [15:0]           frame_cnt
);

  localparam logic [15:0] W16      = 16'(IM_WIDTH);
  localparam logic [15:0] H16      = 16'(IM_HEIGHT);
  localparam logic [15:0] X_LAST   = 16'(IM_WIDTH - 1);
  localparam logic [15:0] Y_LAST   = 16'(IM_HEIGHT - 1);
  localparam logic [15:0] BAR_LAST = 16'(IM_WIDTH / 8 - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic [15:0]           frameCnt_q, frameCnt_d;
  logic [3:0]            nibCnt_q, nibCnt_d;
  logic [15:0]           cntX_q, cntX_d;
  logic [15:0]           cntY_q, cntY_d;
  logic [2:0]            barIdx_q, barIdx_d;
  logic [15:0]           barCnt_q, barCnt_d;
  pattern_e              pat_q, pat_d;
  logic [DATA_WIDTH-1:0] flat_q, flat_d;

  logic [15:0]           nextX, nextY, nextBarCnt;
  logic [2:0]            nextBar;
  logic [DATA_WIDTH-1:0] nextPixel;
  logic                  accept;
  logic                  launch;

  assign accept = valid_q & vst_ready;

  function automatic logic [3:0] ctrlNibble(input logic [3:0] idx);
    case (idx)
      4'd0:    ctrlNibble = W16[15:12];
      4'd1:    ctrlNibble = W16[11:8];
      4'd2:    ctrlNibble = W16[7:4];
      4'd3:    ctrlNibble = W16[3:0];
      4'd4:    ctrlNibble = H16[15:12];
      4'd5:    ctrlNibble = H16[11:8];
      4'd6:    ctrlNibble = H16[7:4];
      4'd7:    ctrlNibble = H16[3:0];
      default: ctrlNibble = INTERLACE_NIBBLE;
    endcase
  endfunction

  // Position of the pixel that follows the current beat; the video header
  // is followed by the origin.
  always_comb begin
    nextX      = '0;
    nextY      = '0;
    nextBar    = '0;
    nextBarCnt = '0;
    if (state_q == ST_VID_PIX) begin
      if (cntX_q == X_LAST) begin
        nextY = cntY_q + 16'd1;
      end else begin
        nextX = cntX_q + 16'd1;
        nextY = cntY_q;
        if (barCnt_q == BAR_LAST) begin
          nextBarCnt = '0;
          nextBar    = (barIdx_q == 3'd7) ? 3'd7 : barIdx_q + 3'd1;
        end else begin
          nextBarCnt = barCnt_q + 16'd1;
          nextBar    = barIdx_q;
        end
      end
    end
  end

  dis_pal_pattern_pixel #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHECK_LOG2 (CHECK_LOG2)
  ) u_pixel (
    .pattern_i    (pat_q),
    .cnt_x_i      (nextX),
    .cnt_y_i      (nextY),
    .bar_idx_i    (nextBar),
    .flat_value_i (flat_q),
    .pixel_o      (nextPixel)
  );

  // Output registers only move on accept (or on leaving IDLE), so a stalled
  // beat is held untouched.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = valid_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    frameCnt_d = frameCnt_q;
    nibCnt_d   = nibCnt_q;
    cntX_d     = cntX_q;
    cntY_d     = cntY_q;
    barIdx_d   = barIdx_q;
    barCnt_d   = barCnt_q;
    pat_d      = pat_q;
    flat_d     = flat_q;
    launch     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        launch = enable;
      end
      ST_CTRL_HDR: begin
        if (accept) begin
          state_d  = ST_CTRL_DAT;
          nibCnt_d = '0;
          data_d   = DATA_WIDTH'(ctrlNibble(4'd0));
          sop_d    = 1'b0;
          eop_d    = 1'b0;
        end
      end
      ST_CTRL_DAT: begin
        if (accept) begin
          if (nibCnt_q == 4'd8) begin
            state_d = ST_VID_HDR;
            data_d  = DATA_WIDTH'(PKT_VIDEO);
            sop_d   = 1'b1;
            eop_d   = 1'b0;
          end else begin
            nibCnt_d = nibCnt_q + 4'd1;
            data_d   = DATA_WIDTH'(ctrlNibble(nibCnt_q + 4'd1));
            eop_d    = (nibCnt_q + 4'd1 == 4'd8);
          end
        end
      end
      ST_VID_HDR, ST_VID_PIX: begin
        if (accept) begin
          if (state_q == ST_VID_PIX && eop_q) begin
            frameCnt_d = frameCnt_q + 16'd1;
            if (enable) begin
              launch = 1'b1;
            end else begin
              state_d = ST_IDLE;
              data_d  = '0;
              valid_d = 1'b0;
              sop_d   = 1'b0;
              eop_d   = 1'b0;
            end
          end else begin
            state_d  = ST_VID_PIX;
            cntX_d   = nextX;
            cntY_d   = nextY;
            barIdx_d = nextBar;
            barCnt_d = nextBarCnt;
            data_d   = nextPixel;
            sop_d    = 1'b0;
            eop_d    = (nextX == X_LAST) && (nextY == Y_LAST);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (launch) begin
      state_d = ST_CTRL_HDR;
      data_d  = DATA_WIDTH'(PKT_CTRL);
      valid_d = 1'b1;
      sop_d   = 1'b1;
      eop_d   = 1'b0;
      pat_d   = pattern_e'(pattern_sel);
      flat_d  = flat_value;
    end
  end

  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      frameCnt_q <= '0;
      nibCnt_q   <= '0;
      cntX_q     <= '0;
      cntY_q     <= '0;
      barIdx_q   <= '0;
      barCnt_q   <= '0;
      pat_q      <= PAT_BARS;
      flat_q     <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      frameCnt_q <= frameCnt_d;
      nibCnt_q   <= nibCnt_d;
      cntX_q     <= cntX_d;
      cntY_q     <= cntY_d;
      barIdx_q   <= barIdx_d;
      barCnt_q   <= barCnt_d;
      pat_q      <= pat_d;
      flat_q     <= flat_d;
    end
  end

  assign vst_data          = data_q;
  assign vst_valid         = valid_q;
  assign vst_startofpacket = sop_q;
  assign vst_endofpacket   = eop_q;
  assign frame_cnt         = frameCnt_q;

endmodule

// File: tb/tb_dis_pal_pattern_gen.sv
// Bench for dis_pal_pattern_gen: random ready/pattern stimulus scored against
// a packet-level model built from the stream format and pattern formulas.
module tb_dis_pal_pattern_gen;

  localparam int         DW  = 10;
  localparam int         IMW = 20;
  localparam int         IMH = 4;
  localparam logic [3:0] ILN = 4'hA;
  localparam int         CL2 = 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic          clk = 1'b0;
  logic          vst_rst_n;
  logic          enable;
  logic [1:0]    pattern_sel;
  logic [DW-1:0] flat_value;
  logic [DW-1:0] vst_data;
  logic          vst_valid;
  logic          vst_ready;
  logic          vst_startofpacket;
  logic          vst_endofpacket;
  logic [15:0]   frame_cnt;

  int     compareCount = 0;
  int     failCount    = 0;
  beat_t  expQ[$];
  beat_t  expBeat;
  beat_t  heldBeat;
  logic   holdPending  = 1'b0;
  logic   modelBusy    = 1'b0;
  logic [15:0] modelFrames = '0;
  logic   readyRandom  = 1'b0;

  dis_pal_pattern_gen #(
    .DATA_WIDTH       (DW),
    .IM_WIDTH         (IMW),
    .IM_HEIGHT        (IMH),
    .INTERLACE_NIBBLE (ILN),
    .CHECK_LOG2       (CL2)
  ) dut (
    .vst_clk           (clk),
    .vst_rst_n         (vst_rst_n),
    .enable            (enable),
    .pattern_sel       (pattern_sel),
    .flat_value        (flat_value),
    .vst_data          (vst_data),
    .vst_valid         (vst_valid),
    .vst_ready         (vst_ready),
    .vst_startofpacket (vst_startofpacket),
    .vst_endofpacket   (vst_endofpacket),
    .frame_cnt         (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int refPixel(input int pat, input int x, input int y, input int flat);
    int bar;
    case (pat)
      0: begin
        bar = x / (IMW / 8);
        if (bar > 7) bar = 7;
        return (7 - bar) * (1 << (DW - 3));
      end
      1: return x % (1 << DW);
      2: return (((x >> CL2) ^ (y >> CL2)) & 1) ? (1 << DW) - 1 : 0;
      default: return flat;
    endcase
  endfunction

  task automatic buildPair(input int pat, input int flat);
    int nib[9];
    for (int i = 0; i < 4; i++) begin
      nib[i]     = (IMW >> (12 - 4 * i)) & 15;
      nib[i + 4] = (IMH >> (12 - 4 * i)) & 15;
    end
    nib[8] = int'(ILN);
    expQ.push_back('{data: DW'(15), sop: 1'b1, eop: 1'b0});
    for (int i = 0; i < 9; i++)
      expQ.push_back('{data: DW'(nib[i]), sop: 1'b0, eop: (i == 8)});
    expQ.push_back('{data: '0, sop: 1'b1, eop: 1'b0});
    for (int y = 0; y < IMH; y++)
      for (int x = 0; x < IMW; x++)
        expQ.push_back('{data: DW'(refPixel(pat, x, y, flat)), sop: 1'b0,
                         eop: (x == IMW - 1) && (y == IMH - 1)});
  endtask

  always @(negedge clk) begin
    if (!vst_rst_n) begin
      checkOutput("rstValid", 32'(vst_valid), 0);
      checkOutput("rstData", 32'(vst_data), 0);
      checkOutput("rstSop", 32'(vst_startofpacket), 0);
      checkOutput("rstEop", 32'(vst_endofpacket), 0);
      checkOutput("rstFrameCnt", 32'(frame_cnt), 0);
      expQ.delete();
      modelBusy   = 1'b0;
      modelFrames = '0;
      holdPending = 1'b0;
    end else begin
      checkOutput("frameCnt", 32'(frame_cnt), 32'(modelFrames));
      if (holdPending) begin
        checkOutput("holdData", 32'(vst_data), 32'(heldBeat.data));
        checkOutput("holdSop", 32'(vst_startofpacket), 32'(heldBeat.sop));
        checkOutput("holdEop", 32'(vst_endofpacket), 32'(heldBeat.eop));
      end
      if (modelBusy) begin
        checkOutput("validHigh", 32'(vst_valid), 1);
        if (vst_valid && vst_ready) begin
          expBeat = expQ.pop_front();
          checkOutput("beatData", 32'(vst_data), 32'(expBeat.data));
          checkOutput("beatSop", 32'(vst_startofpacket), 32'(expBeat.sop));
          checkOutput("beatEop", 32'(vst_endofpacket), 32'(expBeat.eop));
          if (expQ.size() == 0) begin
            modelFrames = modelFrames + 16'd1;
            modelBusy   = 1'b0;
            if (enable) begin
              buildPair(int'(pattern_sel), int'(flat_value));
              modelBusy = 1'b1;
            end
          end
        end
      end else begin
        checkOutput("idleValid", 32'(vst_valid), 0);
        if (enable) begin
          buildPair(int'(pattern_sel), int'(flat_value));
          modelBusy = 1'b1;
        end
      end
      holdPending = vst_valid && !vst_ready;
      heldBeat    = '{data: vst_data, sop: vst_startofpacket, eop: vst_endofpacket};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    vst_ready = readyRandom ? 1'($urandom % 2) : 1'b1;
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] pat,
                               input logic [DW-1:0] flat, input logic rnd);
    enable      = en;
    pattern_sel = pat;
    flat_value  = flat;
    readyRandom = rnd;
  endtask

  task automatic waitFrames(input int n);
    logic [15:0] target;
    int          cycles;
    target = modelFrames + 16'(n);
    cycles = 0;
    while (modelFrames != target && cycles < 2000 * n) begin
      tick();
      cycles++;
    end
    if (modelFrames != target) checkOutput("frameTimeout", 32'(modelFrames), 32'(target));
  endtask

  task automatic waitIdle();
    int cycles;
    cycles = 0;
    while (modelBusy && cycles < 2000) begin
      tick();
      cycles++;
    end
    checkOutput("idleTimeout", 32'(modelBusy), 0);
  endtask

  initial begin
    int cycles;
    vst_rst_n = 1'b0;
    vst_ready = 1'b1;
    applyStimulus(1'b0, 2'd0, '0, 1'b0);
    repeat (3) tick();
    vst_rst_n = 1'b1;
    repeat (3) tick();

    applyStimulus(1'b1, 2'd0, '0, 1'b0);
    waitFrames(2);
    for (int p = 0; p < 8; p++) begin
      applyStimulus(1'b1, 2'(p % 4), DW'($urandom), 1'(p / 4));
      repeat (30) tick();
      waitFrames(2);
    end

    applyStimulus(1'b1, 2'd3, DW'(10'h155), 1'b0);
    waitFrames(2);
    repeat (50) tick();
    applyStimulus(1'b0, 2'd2, '0, 1'b0);
    waitIdle();
    repeat (20) tick();
    checkOutput("idleAfterDrop", 32'(vst_valid), 0);

    applyStimulus(1'b1, 2'd1, DW'($urandom), 1'b1);
    waitFrames(1);
    cycles = 0;
    while (!(vst_valid && vst_startofpacket && vst_data == '0) && cycles < 2000) begin
      tick();
      cycles++;
    end
    repeat (7) tick();
    vst_rst_n = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(vst_valid), 0);
    checkOutput("asyncRstData", 32'(vst_data), 0);
    checkOutput("asyncRstSop", 32'(vst_startofpacket), 0);
    checkOutput("asyncRstFrame", 32'(frame_cnt), 0);
    repeat (3) tick();
    vst_rst_n = 1'b1;
    waitFrames(1);
    applyStimulus(1'b0, 2'd0, '0, 1'b0);
    waitIdle();
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
